spike_propagator: RTL and testbench

Writer/initiator side of the current_update I_next port. It accepts presynaptic spike tags, walks each spike's row of a fully connected weight matrix, and read-modify-writes each postsynaptic neuron's I_next with a saturating add. At end of timestep it drains all in-flight work, then issues the single-cycle swap to current_update.

---
 rtl/spike_propagator_pkg.sv | 23 ++
 rtl/spike_propagator_if.sv | 30 +++
 rtl/spike_propagator_sm_sat_add.sv | 45 ++++
 rtl/spike_propagator.sv | 194 +++++++++++++++++++
 tb/tb_spike_propagator.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_propagator_pkg.sv
// Shared types and constants for the spike propagation path (I_next writer side).
package spike_propagator_pkg;

    localparam int NUMWIDTH   = 16;
    localparam int TAGBITS    = 1;
    localparam int NUMNEURONS = 2;
    localparam int FIFODEPTH  = 4;
    localparam int SIGN_BIT   = NUMWIDTH;

    typedef logic [NUMWIDTH:0]  value_t;
    typedef logic [TAGBITS-1:0] tag_t;

    localparam logic [NUMWIDTH-1:0] MAX_MAG = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROP,
        ST_DRAIN,
        ST_SWAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spike_propagator_if.sv
// I_next read/write/swap bus between spike_propagator (master) and current_update (slave).
interface spike_propagator_if;
    import spike_propagator_pkg::*;

    tag_t   i_next_read_tag;
    value_t i_next_read_value;
    logic   i_next_write_en;
    tag_t   i_next_write_tag;
    value_t i_next_write_value;
    logic   swap;

    modport master (
        output i_next_read_tag,
        input  i_next_read_value,
        output i_next_write_en,
        output i_next_write_tag,
        output i_next_write_value,
        output swap
    );

    modport slave (
        input  i_next_read_tag,
        output i_next_read_value,
        input  i_next_write_en,
        input  i_next_write_tag,
        input  i_next_write_value,
        input  swap
    );

endinterface

// File: rtl/spike_propagator_sm_sat_add.sv
// sm_sat_add: combinational sign-magnitude adder saturating to MAX_MAG; never emits -0.
module sm_sat_add
    import spike_propagator_pkg::*;
(
    input  value_t i_a,
    input  value_t i_b,
    output value_t o_sum
);

    logic [NUMWIDTH-1:0] w_magA;
    logic [NUMWIDTH-1:0] w_magB;
    logic [NUMWIDTH-1:0] w_mag;
    logic [NUMWIDTH:0]   w_rawSum;
    logic                w_signA;
    logic                w_signB;
    logic                w_sign;

    assign w_magA   = i_a[NUMWIDTH-1:0];
    assign w_magB   = i_b[NUMWIDTH-1:0];
    // A zero magnitude carries no sign, so -0 behaves exactly like +0.
    assign w_signA  = i_a[SIGN_BIT] && (w_magA != '0);
    assign w_signB  = i_b[SIGN_BIT] && (w_magB != '0);
    assign w_rawSum = {1'b0, w_magA} + {1'b0, w_magB};

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        if (w_signA == w_signB) begin
            w_mag  = w_rawSum[NUMWIDTH] ? MAX_MAG : w_rawSum[NUMWIDTH-1:0];
            w_sign = w_signA;
        end else if (w_magA >= w_magB) begin
            w_mag  = w_magA - w_magB;
            w_sign = w_signA;
        end else begin
            w_mag  = w_magB - w_magA;
            w_sign = w_signB;
        end
        if (w_mag == '0) begin
            w_sign = 1'b0;
        end
    end

    assign o_sum = {w_sign, w_mag};

endmodule

// File: rtl/spike_propagator.sv
// spike_propagator: queues presynaptic spikes, walks each weight row and read-modify-writes I_next,
// then drains and issues swap at end of timestep. Optional macro SPIKE_COUNT_EN enables spike_count.
module spike_propagator
    import spike_propagator_pkg::*;
#(
    parameter int NUM_NEURONS = NUMNEURONS,
    parameter int FIFO_DEPTH  = FIFODEPTH
) (
    input  logic        clk,
    input  logic        asyn_reset,
    input  logic        spike_valid,
    input  tag_t        spike_tag,
    output logic        spike_ready,
    input  logic        step_end,
    output logic        step_done,
    input  logic        w_we,
    input  tag_t        w_pre,
    input  tag_t        w_post,
    input  value_t      w_data,
    output logic [15:0] spike_count,
    spike_propagator_if.master cu
);

    localparam int   AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int   NW       = 2 ** TAGBITS;
    localparam tag_t LAST_TAG = tag_t'(NUM_NEURONS - 1);

    state_t        r_state;
    state_t        w_nextState;
    tag_t          r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    tag_t          r_j;
    tag_t          w_nextJ;
    logic          r_stepPending;
    value_t        r_weight [NW][NW];

    logic          r_s2Valid;
    tag_t          r_s2Tag;
    value_t        r_s2Weight;
    logic          r_prevWrEn;
    tag_t          r_prevTag;
    value_t        r_prevValue;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_willEmpty;
    tag_t          w_head;
    value_t        w_operand;
    value_t        w_sum;

    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign spike_ready = !w_full && !r_stepPending;
    assign w_push      = spike_valid && spike_ready;
    assign w_head      = r_fifo[r_rdPtr];
    assign w_willEmpty = (r_count == (AW+1)'(1)) && !w_push;

    // Storage without reset: weights persist across resets, FIFO slots are guarded by r_count.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_weight[w_pre][w_post] <= w_data;
        end
        if (w_push) begin
            r_fifo[r_wrPtr] <= spike_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_state       <= ST_IDLE;
            r_j           <= '0;
            r_stepPending <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_j     <= w_nextJ;
            if (step_end) begin
                r_stepPending <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_stepPending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextJ     = r_j;
        w_issue     = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_nextState = ST_PROP;
                    w_nextJ     = '0;
                end else if (r_stepPending || step_end) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_PROP: begin
                w_issue = 1'b1;
                if (r_j == LAST_TAG) begin
                    w_pop   = 1'b1;
                    w_nextJ = '0;
                    if (w_willEmpty) begin
                        w_nextState = (r_stepPending || step_end) ? ST_DRAIN : ST_IDLE;
                    end
                end else begin
                    w_nextJ = r_j + tag_t'(1);
                end
            end
            ST_DRAIN: w_nextState = ST_SWAP;
            ST_SWAP:  w_nextState = ST_DONE;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Stage 2 holds the issued target; the prev* copy forwards a write the memory has not yet absorbed.
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_s2Valid   <= 1'b0;
            r_s2Tag     <= '0;
            r_s2Weight  <= '0;
            r_prevWrEn  <= 1'b0;
            r_prevTag   <= '0;
            r_prevValue <= '0;
        end else begin
            r_s2Valid   <= w_issue;
            r_s2Tag     <= r_j;
            r_s2Weight  <= r_weight[w_head][r_j];
            r_prevWrEn  <= r_s2Valid;
            r_prevTag   <= r_s2Tag;
            r_prevValue <= w_sum;
        end
    end

    assign w_operand = (r_prevWrEn && (r_prevTag == r_s2Tag)) ? r_prevValue : cu.i_next_read_value;

    sm_sat_add u_satAdd (
        .i_a   (w_operand),
        .i_b   (r_s2Weight),
        .o_sum (w_sum)
    );

    assign cu.i_next_read_tag    = r_j;
    assign cu.i_next_write_en    = r_s2Valid;
    assign cu.i_next_write_tag   = r_s2Tag;
    assign cu.i_next_write_value = r_s2Valid ? w_sum : '0;
    assign cu.swap               = (r_state == ST_SWAP);
    assign step_done             = (r_state == ST_DONE);

`ifdef SPIKE_COUNT_EN
    logic [15:0] r_spikeCount;

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_spikeCount <= '0;
        end else if (r_state == ST_DONE) begin
            r_spikeCount <= '0;
        end else if (w_pop && (r_spikeCount != 16'hFFFF)) begin
            r_spikeCount <= r_spikeCount + 16'd1;
        end
    end

    assign spike_count = r_spikeCount;
`else
    assign spike_count = '0;
`endif

endmodule

// File: tb/tb_spike_propagator.sv
// Bench for spike_propagator: models current_update's I_next memory for a 2-neuron and a 1-neuron instance.
module tb_spike_propagator;
    import spike_propagator_pkg::*;

`ifdef SPIKE_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        tag_t        wtag;
        value_t      val;
    } wr_t;

    logic        clk;
    logic        asyn_reset;

    logic        aValid, aReady, aStepEnd, aStepDone, aWe;
    tag_t        aTag, aPre, aPost;
    value_t      aData;
    logic [15:0] aCount;

    logic        bValid, bReady, bStepEnd, bStepDone, bWe;
    tag_t        bTag, bPre, bPost;
    value_t      bData;
    logic [15:0] bCount;

    logic        presetEn;
    tag_t        presetTag;
    value_t      presetVal;

    value_t      memA [2];
    value_t      memB [2];
    int          swapCntA;
    int          cycleCnt;
    int          checkCnt;
    int          passCnt;
    wr_t         logA [$];
    wr_t         logB [$];

    spike_propagator_if ifA ();
    spike_propagator_if ifB ();

    spike_propagator #(.NUM_NEURONS(2), .FIFO_DEPTH(4)) dutA (
        .clk         (clk),
        .asyn_reset  (asyn_reset),
        .spike_valid (aValid),
        .spike_tag   (aTag),
        .spike_ready (aReady),
        .step_end    (aStepEnd),
        .step_done   (aStepDone),
        .w_we        (aWe),
        .w_pre       (aPre),
        .w_post      (aPost),
        .w_data      (aData),
        .spike_count (aCount),
        .cu          (ifA)
    );

    spike_propagator #(.NUM_NEURONS(1), .FIFO_DEPTH(4)) dutB (
        .clk         (clk),
        .asyn_reset  (asyn_reset),
        .spike_valid (bValid),
        .spike_tag   (bTag),
        .spike_ready (bReady),
        .step_end    (bStepEnd),
        .step_done   (bStepDone),
        .w_we        (bWe),
        .w_pre       (bPre),
        .w_post      (bPost),
        .w_data      (bData),
        .spike_count (bCount),
        .cu          (ifB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // current_update model: registered read (old data on same-edge write), write on write_en.
    always @(posedge clk) begin
        if (asyn_reset) begin
            memA[0] <= '0;
            memA[1] <= '0;
            ifA.i_next_read_value <= '0;
            swapCntA <= 0;
        end else begin
            ifA.i_next_read_value <= memA[ifA.i_next_read_tag];
            if (ifA.i_next_write_en) memA[ifA.i_next_write_tag] <= ifA.i_next_write_value;
            if (presetEn) memA[presetTag] <= presetVal;
            if (ifA.swap) swapCntA <= swapCntA + 1;
        end
    end

    always @(posedge clk) begin
        if (asyn_reset) begin
            memB[0] <= '0;
            memB[1] <= '0;
            ifB.i_next_read_value <= '0;
        end else begin
            ifB.i_next_read_value <= memB[ifB.i_next_read_tag];
            if (ifB.i_next_write_en) memB[ifB.i_next_write_tag] <= ifB.i_next_write_value;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            passCnt++;
        end
    endtask

    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        cycleCnt++;
        if (ifA.i_next_write_en) begin
            e.cyc  = 32'(cycleCnt);
            e.wtag = ifA.i_next_write_tag;
            e.val  = ifA.i_next_write_value;
            logA.push_back(e);
        end
        if (ifB.i_next_write_en) begin
            e.cyc  = 32'(cycleCnt);
            e.wtag = ifB.i_next_write_tag;
            e.val  = ifB.i_next_write_value;
            logB.push_back(e);
        end
    endtask

    task automatic applyReset();
        asyn_reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic applyWeightA(input tag_t pre, input tag_t post, input value_t val);
        aWe = 1'b1; aPre = pre; aPost = post; aData = val;
        tick();
        aWe = 1'b0;
    endtask

    task automatic applyPreset(input tag_t t, input value_t val);
        presetEn = 1'b1; presetTag = t; presetVal = val;
        tick();
        presetEn = 1'b0;
    endtask

    task automatic checkWrite(input string name, input bit selB, input int idx,
                              input tag_t expTag, input value_t expVal, input int expCyc);
        wr_t e;
        int  n;
        string nm;
        nm = $sformatf("%s.w%0d", name, idx);
        n = selB ? logB.size() : logA.size();
        if (idx >= n) begin
            checkOutput({nm, ".present"}, 32'(n), 32'(idx + 1));
        end else begin
            e = selB ? logB[idx] : logA[idx];
            checkOutput({nm, ".tag"}, 32'(e.wtag), 32'(expTag));
            checkOutput({nm, ".val"}, 32'(e.val), 32'(expVal));
            checkOutput({nm, ".cyc"}, e.cyc, 32'(expCyc));
        end
    endtask

    // One spike on the 2-neuron instance: writes to tag 0 then tag 1, two and three cycles after push.
    task automatic runSpikeA(input string name, input tag_t t, input value_t exp0, input value_t exp1);
        int pushCyc;
        logA.delete();
        aValid = 1'b1; aTag = t;
        tick();
        aValid = 1'b0;
        pushCyc = cycleCnt;
        repeat (6) tick();
        checkOutput({name, ".nWrites"}, 32'(logA.size()), 32'd2);
        checkWrite(name, 1'b0, 0, tag_t'(0), exp0, pushCyc + 2);
        checkWrite(name, 1'b0, 1, tag_t'(1), exp1, pushCyc + 3);
    endtask

    initial begin
        int     pushCyc;
        int     idx;
        int     cyc0;
        logic   acc;
        tag_t   fifoTags [5];
        logic   readyExp [6];
        value_t fifoVals [10];

        checkCnt = 0; passCnt = 0; cycleCnt = 0;
        asyn_reset = 1'b1;
        aValid = 0; aTag = '0; aStepEnd = 0; aWe = 0; aPre = '0; aPost = '0; aData = '0;
        bValid = 0; bTag = '0; bStepEnd = 0; bWe = 0; bPre = '0; bPost = '0; bData = '0;
        presetEn = 0; presetTag = '0; presetVal = '0;

        applyReset();
        checkOutput("rst.ready",     32'(aReady), 32'd1);
        checkOutput("rst.wen",       32'(ifA.i_next_write_en), 32'd0);
        checkOutput("rst.swap",      32'(ifA.swap), 32'd0);
        checkOutput("rst.stepDone",  32'(aStepDone), 32'd0);
        checkOutput("rst.count",     32'(aCount), 32'd0);
        checkOutput("rst.readTag",   32'(ifA.i_next_read_tag), 32'd0);
        checkOutput("rst.writeTag",  32'(ifA.i_next_write_tag), 32'd0);
        checkOutput("rst.writeVal",  32'(ifA.i_next_write_value), 32'd0);
        asyn_reset = 1'b0;
        tick();

        applyWeightA(1'b0, 1'b0, 17'h00005);
        applyWeightA(1'b0, 1'b1, 17'h10003);
        applyWeightA(1'b1, 1'b0, 17'h00005);
        applyWeightA(1'b1, 1'b1, 17'h10003);

        // Basic propagation with explicit read-tag timing.
        logA.delete();
        aValid = 1'b1; aTag = 1'b0;
        tick();
        aValid = 1'b0;
        pushCyc = cycleCnt;
        checkOutput("basic.wenAtPush", 32'(ifA.i_next_write_en), 32'd0);
        tick();
        checkOutput("basic.readTag0", 32'(ifA.i_next_read_tag), 32'd0);
        checkOutput("basic.wenBeforeWrite", 32'(ifA.i_next_write_en), 32'd0);
        tick();
        checkOutput("basic.readTag1", 32'(ifA.i_next_read_tag), 32'd1);
        repeat (4) tick();
        checkOutput("basic.nWrites", 32'(logA.size()), 32'd2);
        checkWrite("basic", 1'b0, 0, 1'b0, 17'h00005, pushCyc + 2);
        checkWrite("basic", 1'b0, 1, 1'b1, 17'h10003, pushCyc + 3);
        checkOutput("basic.mem0", 32'(memA[0]), 32'h00005);
        checkOutput("basic.mem1", 32'(memA[1]), 32'h10003);

        runSpikeA("accum", 1'b0, 17'h0000A, 17'h10006);

        applyPreset(1'b0, 17'h0FFFE);
        applyPreset(1'b1, 17'h00003);
        runSpikeA("sat", 1'b1, 17'h0FFFF, 17'h00000);

        applyPreset(1'b0, 17'h10000);
        applyPreset(1'b1, 17'h00001);
        runSpikeA("mix", 1'b1, 17'h00005, 17'h10002);

        // Forwarding on the single-neuron instance: back-to-back same-tag writes.
        bWe = 1'b1; bPre = 1'b0; bPost = 1'b0; bData = 17'h00007;
        tick();
        bWe = 1'b0;
        logB.delete();
        bValid = 1'b1; bTag = 1'b0;
        tick();
        pushCyc = cycleCnt;
        tick();
        bValid = 1'b0;
        repeat (6) tick();
        checkOutput("fwd.nWrites", 32'(logB.size()), 32'd2);
        checkWrite("fwd", 1'b1, 0, 1'b0, 17'h00007, pushCyc + 2);
        checkWrite("fwd", 1'b1, 1, 1'b0, 17'h0000E, pushCyc + 3);
        checkOutput("fwd.mem0", 32'(memB[0]), 32'h0000E);

        // FIFO fill while propagating; order shows up in the running sums.
        applyWeightA(1'b0, 1'b0, 17'h00001);
        applyWeightA(1'b0, 1'b1, 17'h00001);
        applyWeightA(1'b1, 1'b0, 17'h00100);
        applyWeightA(1'b1, 1'b1, 17'h00100);
        applyPreset(1'b0, 17'h00000);
        applyPreset(1'b1, 17'h00000);
        fifoTags = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        readyExp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        fifoVals = '{17'h00100, 17'h00100, 17'h00101, 17'h00101, 17'h00102,
                     17'h00102, 17'h00202, 17'h00202, 17'h00203, 17'h00203};
        logA.delete();
        idx = 0;
        cyc0 = 0;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("fifo.ready%0d", k), 32'(aReady), 32'(readyExp[k]));
            if (idx < 5) begin
                aValid = 1'b1;
                aTag = fifoTags[idx];
            end else begin
                aValid = 1'b0;
            end
            acc = aValid && aReady;
            tick();
            if (k == 0) cyc0 = cycleCnt;
            if (acc) idx++;
        end
        aValid = 1'b0;
        checkOutput("fifo.accepted", 32'(idx), 32'd5);
        repeat (14) tick();
        checkOutput("fifo.nWrites", 32'(logA.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            checkWrite("fifo", 1'b0, i, tag_t'(i % 2), fifoVals[i], cyc0 + 2 + i);
        end

        // End of timestep: drain, single swap, done pulse.
        applyReset();
        asyn_reset = 1'b0;
        tick();
        logA.delete();
        aValid = 1'b1; aTag = 1'b0;
        tick();
        aValid = 1'b0;
        pushCyc = cycleCnt;
        tick();
        aStepEnd = 1'b1;
        tick();
        aStepEnd = 1'b0;
        checkOutput("step.readyPending", 32'(aReady), 32'd0);
        checkOutput("step.swapEarly", 32'(ifA.swap), 32'd0);
        tick();
        checkOutput("step.lastWrite", 32'(ifA.i_next_write_en), 32'd1);
        checkOutput("step.swapDrain", 32'(ifA.swap), 32'd0);
        tick();
        checkOutput("step.swap", 32'(ifA.swap), 32'd1);
        checkOutput("step.wenAtSwap", 32'(ifA.i_next_write_en), 32'd0);
        checkOutput("step.doneAtSwap", 32'(aStepDone), 32'd0);
        checkOutput("step.countAtSwap", 32'(aCount), 32'(CNT_ON));
        tick();
        checkOutput("step.swapOff", 32'(ifA.swap), 32'd0);
        checkOutput("step.done", 32'(aStepDone), 32'd1);
        checkOutput("step.countAtDone", 32'(aCount), 32'(CNT_ON));
        tick();
        checkOutput("step.doneOff", 32'(aStepDone), 32'd0);
        checkOutput("step.countCleared", 32'(aCount), 32'd0);
        checkOutput("step.readyAgain", 32'(aReady), 32'd1);
        repeat (3) tick();
        checkOutput("step.swapCount", 32'(swapCntA), 32'd1);
        checkOutput("step.nWrites", 32'(logA.size()), 32'd2);
        checkWrite("step", 1'b0, 0, 1'b0, 17'h00001, pushCyc + 2);
        checkWrite("step", 1'b0, 1, 1'b1, 17'h00001, pushCyc + 3);

        // Reset while propagating abandons the pending write.
        logA.delete();
        aValid = 1'b1; aTag = 1'b0;
        tick();
        aValid = 1'b0;
        tick();
        asyn_reset = 1'b1;
        tick();
        checkOutput("midRst.wen", 32'(ifA.i_next_write_en), 32'd0);
        checkOutput("midRst.swap", 32'(ifA.swap), 32'd0);
        checkOutput("midRst.ready", 32'(aReady), 32'd1);
        asyn_reset = 1'b0;
        repeat (3) tick();
        checkOutput("midRst.noWrites", 32'(logA.size()), 32'd0);
        runSpikeA("postRst", 1'b0, 17'h00001, 17'h00001);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
